dmem_responder: RTL

- Data-memory responder for the pipelined MIPS core: the memory end of the core's load/store interface (address, write data, write enable in; read data out).
- Word-organised synchronous RAM behind a request/ready handshake, with a programmable wait-state count.
- Drives a stall output so the core freezes its pipeline until the access completes.
- Flags misaligned and out-of-range accesses instead of performing them.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined MIPS core: word-organised synchronous RAM
// behind a req/ready handshake with a fixed number of wait states and address checking.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        stall,
    output logic        addr_err
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Rejects byte-misaligned addresses and anything beyond the RAM's byte range.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (ADDR_WIDTH + 2);
        return (a[1:0] != 2'd0) || (hi != 32'd0);
    endfunction

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [3:0]              wait_cnt_r;
    logic                    wr_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;
    logic [31:0]             ram_r [DEPTH];
    logic                    acc_wr_s;
    logic [31:0]             acc_addr_s;
    logic [31:0]             acc_wdata_s;
    logic                    acc_err_s;
    logic [ADDR_WIDTH-1:0]   acc_idx_s;
    logic                    enter_resp_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req && HAS_WAIT) begin
                    state_nxt_s = ST_WAIT;
                end else if (req) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pipeline freeze: held from the request cycle until the response cycle
    always_comb begin
        stall = ((state_r == ST_IDLE) && req) || (state_r == ST_WAIT);
    end

    // Request capture and wait-state counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
            wr_r       <= 1'b0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
        end else if ((state_r == ST_IDLE) && req) begin
            wait_cnt_r <= WAIT_INIT;
            wr_r       <= mem_write;
            addr_r     <= addr;
            wdata_r    <= write_data;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // With no wait states the access happens on the accepting edge, so use the live inputs
    always_comb begin
        acc_wr_s    = wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            acc_wr_s    = mem_write;
            acc_addr_s  = addr;
            acc_wdata_s = write_data;
        end else begin
            acc_wr_s    = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        acc_err_s    = addr_bad(acc_addr_s);
        acc_idx_s    = acc_addr_s[ADDR_WIDTH+1:2];
        enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (rst && enter_resp_s && acc_wr_s && !acc_err_s) begin
            ram_r[acc_idx_s] <= acc_wdata_s;
        end
    end

    // Registered response: ready/addr_err pulse for the RESP cycle, load data held until replaced
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= 32'd0;
            ready     <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ready    <= enter_resp_s;
            addr_err <= enter_resp_s && acc_err_s;
            if (enter_resp_s && !acc_wr_s) begin
                read_data <= acc_err_s ? 32'd0 : ram_r[acc_idx_s];
            end
        end
    end

endmodule
